// File: rtl/alu_flag_stage.sv
// ALU result/flag stage: 2-entry writeback FIFO plus {N,Z,C,V} status register.
// Optional ALU_FLAG_BORROW_EN: C holds borrow (~cout) on subtraction instead of raw carry.
module alu_flag_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] s,
   input  logic       cout,
   input  logic       overflow,
   input  logic       sub,
   input  logic [2:0] dest,
   input  logic       flag_we,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] wb_data,
   output logic [2:0] wb_dest,
   output logic [3:0] flags
);

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] dest;
   } entry_t;

   entry_t [1:0] mem;
   logic   [1:0] count;
   logic         wr_ptr;
   logic         rd_ptr;
   logic         accept;
   logic         release_e;
   logic         c_bit;

   // Ready comes only from count, so no comb path from out_ready/in_valid.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid & in_ready;
   assign release_e = out_valid & out_ready;
   assign wb_data   = mem[rd_ptr].data;
   assign wb_dest   = mem[rd_ptr].dest;

`ifdef ALU_FLAG_BORROW_EN
   assign c_bit = sub ? ~cout : cout;
`else
   assign c_bit = cout;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '0;
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         flags  <= 4'b0000;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= '{data: s, dest: dest};
            wr_ptr      <= ~wr_ptr;
            if (flag_we)
               flags <= {s[7], (s == 8'h00), c_bit, overflow};
         end
         if (release_e)
            rd_ptr <= ~rd_ptr;
         case ({accept, release_e})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
